// File: rtl/fwd_mux_stage.sv
// fwd_mux_stage: N-way operand select feeding a two-entry FIFO skid buffer
// with a valid/ready output handshake. Out-of-range selects yield zero and
// are counted in a sticky error flag plus a saturating 8-bit counter.
module fwd_mux_stage #(
   parameter int N      = 32,
   parameter int NUM_IN = 4,
   parameter int SELW   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SELW-1:0]       sel,
   input  logic [NUM_IN*N-1:0]   data_in,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          F,
   output logic [SELW-1:0]       out_sel,
   output logic                  err,
   output logic [7:0]            err_cnt
);

   localparam logic [SELW:0] NUM_IN_W = (SELW+1)'(NUM_IN);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e            state_q, state_d;
   logic            head_q, head_d;
   logic [N-1:0]    data0_q, data0_d, data1_q, data1_d;
   logic [SELW-1:0] sel0_q, sel0_d, sel1_q, sel1_d;
   logic            err_q, err_d;
   logic [7:0]      cnt_q, cnt_d;

   logic [N-1:0]    sel_data;
   logic            in_range;
   logic            push, pop, wr_ptr;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   // Tail slot: the head itself when empty, the other slot when one entry is held.
   assign wr_ptr    = head_q ^ (state_q == ONE);

   assign F       = head_q ? data1_q : data0_q;
   assign out_sel = head_q ? sel1_q  : sel0_q;
   assign err     = err_q;
   assign err_cnt = cnt_q;

   // Operand select; out-of-range indices produce zero.
   always_comb begin
      sel_data = '0;
      in_range = ({1'b0, sel} < NUM_IN_W);
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (SELW'(k) == sel) sel_data = data_in[k*N +: N];
      end
   end

   // Next-state for buffer storage, occupancy and error accounting.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      data0_d = data0_q;
      data1_d = data1_q;
      sel0_d  = sel0_q;
      sel1_d  = sel1_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      if (push) begin
         if (wr_ptr) begin
            data1_d = sel_data;
            sel1_d  = sel;
         end else begin
            data0_d = sel_data;
            sel0_d  = sel;
         end
         if (!in_range) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         end
      end

      if (pop) head_d = ~head_q;

      case (state_q)
         EMPTY:   if (push) state_d = ONE;
         ONE:     if (push && !pop) state_d = FULL;
                  else if (!push && pop) state_d = EMPTY;
         FULL:    if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase

      if (flush) state_d = EMPTY;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         sel0_q  <= '0;
         sel1_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         sel0_q  <= sel0_d;
         sel1_q  <= sel1_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/fwd_mux_stage.md
# fwd_mux_stage

Parametrised N-way operand-select pipeline stage for the EX-stage forwarding path. Selects one of NUM_IN operand sources per transaction, registers the result and drives it downstream over a valid/ready handshake. A two-entry skid buffer sustains full throughput under backpressure. Out-of-range selects produce zero, which matches the legacy 3:1 select behaviour, and raise a sticky error flag plus an event count.

## Interface
Parameters:
- N, default 32: operand width in bits.
- NUM_IN, default 4: number of selectable sources. Legal values are 2..8.
- SELW, default 3: select width. Must satisfy 2^SELW ≥ NUM_IN.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream offers a transaction.
- in_ready, output, 1: stage can accept a transaction.
- sel, input, SELW: source index for the offered transaction.
- data_in, input, NUM_IN*N: flattened sources. Source k occupies bits [k*N +: N].
- flush, input, 1: discards all buffered transactions (pipeline squash).
- out_valid, output, 1: F/out_sel hold a valid transaction.
- out_ready, input, 1: downstream accepts the transaction.
- F, output, N: selected operand.
- out_sel, output, SELW: select value that produced F.
- err, output, 1: sticky flag. Set when any out-of-range sel was accepted.
- err_cnt, output, 8: number of accepted out-of-range selects. Saturates at 255.

## Operation
- A transaction is accepted when in_valid && in_ready && !flush at a clock edge.
- At acceptance, the stage captures:
  - data_in[sel*N +: N] if sel < NUM_IN, otherwise all zeros;
  - the sel value itself.
- The buffer is two entries deep and first-in, first-out. Its occupancy count is 0, 1 or 2.
- State per occupancy:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - FULL (2): out_valid=1, in_ready=0.
- Occupancy transitions (push = acceptance, pop = out_valid && out_ready):
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, head advances.
  - Push while FULL is impossible because in_ready=0.
- Flush:
  - The next state is EMPTY regardless of push or pop.
  - Any input offered in the flush cycle is dropped and does not update err or err_cnt.
- Error accounting:
  - An accepted sel ≥ NUM_IN sets err and increments err_cnt by 1. err_cnt saturates at 255.
  - Out-of-range transactions still flow through as F=0 with out_sel unchanged.
- F and out_sel always reflect the head entry. When count=0 they hold their last value, which is don't-care.

## Timing
- Reset values, effective the cycle after rst is sampled high:
  - out_valid=0, F=0, out_sel=0, count=0;
  - err=0, err_cnt=0;
  - in_ready=1.
- While rst is high, in_valid, out_ready and flush are ignored.
- Latency: a transaction accepted at edge t appears with out_valid=1 from edge t onward, i.e. it is visible in cycle t+1.
- Throughput: one transaction per cycle while out_ready=1.
- in_ready depends on registered occupancy only. There is no combinational path from out_ready or in_valid to in_ready.
- Reset asserted mid-stream: buffered data is lost. Behaviour matches the flush case, and in addition err and err_cnt are cleared.
- flush and rst asserted together: rst takes effect.
- out_valid, once high, must not drop without a pop, flush or reset. F must not change while out_valid=1 && !out_ready.

## Test plan
- **Reset.** Drive rst=1 for 2 cycles with in_valid=1 → out_valid=0, F=0, err=0, err_cnt=0, in_ready=1 on release.
- **Streaming.** NUM_IN=4, sources 0x11,0x22,0x33,0x44, out_ready=1, sel=0,1,2,3 on consecutive cycles → F=0x11,0x22,0x33,0x44 one cycle after each, with no bubbles.
- **Backpressure.** With out_ready=0, push 0xA then 0xB → in_ready=0 after the second push and F holds 0xA. A third offer of 0xC is not accepted. Raise out_ready → 0xA, then 0xB, then 0xC once re-offered.
- **Out-of-range select.** sel=5 with NUM_IN=4 → F=0, out_sel=5, err=1, err_cnt=1. Repeat 300 times → err_cnt saturates at 255.
- **Flush.** Hold FULL, then flush=1 with in_valid=1 → next cycle count=0, out_valid=0, and the offered input is absent. err is unchanged even if its sel was out of range.
- **Simultaneous events.** In ONE state, push and pop together → count stays 1 and F shows the new entry. Assert flush and rst together in FULL → reset values, err_cnt=0.
